switch_capture_fifo: RTL and testbench
======================================

// Module: switch_capture_fifo
// PURPOSE
//   Downstream consumer of the debounced button stage. Edge-detects the debounced
//   confirm-button level and, on each press, captures the board switch word into
//   a small FIFO. The CPU's MMIO input port drains that FIFO one word per read
//   strobe. Status flags (valid/full/count/sticky overflow) are exported for
//   polling, so no press is lost while software is busy.
// PARAMETERS
//   DATA_W   16  width of captured switch word
//   DEPTH    4   FIFO entries; must be a power of 2, >= 2
//   ADDR_W   2   log2(DEPTH); pointer width
// PORTS
//   clk        in   1         system clock; all state on posedge
//   rst_n      in   1         asynchronous, active-low reset
//   btn_lvl    in   1         debounced button level (held, not a pulse)
//   sw         in   DATA_W    switch word, already synchronous to clk
//   rd_en      in   1         CPU read strobe, 1 cycle per word
//   clr_ovf    in   1         clears sticky overflow flag
//   rd_data    out  DATA_W    head-of-FIFO word; 0 when empty
//   valid      out  1         FIFO not empty
//   full       out  1         count == DEPTH
//   count      out  ADDR_W+1  occupied entries, 0..DEPTH
//   overflow   out  1         sticky: a press was dropped because FIFO was full
// BEHAVIOUR
//   Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, overflow=0,
//     btn_d=1. Outputs: rd_data=0, valid=0, full=0, count=0, overflow=0.
//     btn_d resets to 1, so a button held through reset release makes no push.
//   Edge detect: btn_d <= btn_lvl each cycle; push = btn_lvl & ~btn_d.
//     Exactly one push per low->high transition of btn_lvl, regardless of hold time.
//   Write: on a push cycle, sw as sampled on that same edge goes to mem[wr_ptr].
//     wr_ptr wraps modulo DEPTH. valid rises the cycle after the first push.
//   Read: pop = rd_en & valid. On pop, rd_ptr advances modulo DEPTH and the next
//     head is on rd_data the following cycle. rd_en while empty: ignored, no
//     state change, no error flag.
//   rd_data = valid ? mem[rd_ptr] : 0 (first-word fall-through, comb from regs).
//   count: +1 on push-only, -1 on pop-only, unchanged on push&pop or neither.
//   full=(count==DEPTH), valid=(count!=0), both derived from registered count.
//   Boundaries:
//     push while full, no pop  -> word dropped, pointers held, overflow <= 1.
//     push & pop while full    -> both happen, count stays DEPTH, no overflow.
//     push & pop while empty   -> push only (pop invalid), count 0->1.
//     clr_ovf with simultaneous drop -> overflow stays 1 (set wins).
//     reset mid-operation      -> all contents discarded, flags as reset above.
//   mem contents are not reset; rd_data is masked to 0 while empty.
//   Arithmetic: pointers ADDR_W bits with natural wrap; count ADDR_W+1 bits,
//     never exceeds DEPTH and never underflows.
// TESTING
//   1 Reset with btn_lvl=1 held, release rst_n, hold btn 20 cycles -> count stays 0,
//     valid=0, no push.
//   2 sw=16'hA5A5, btn_lvl 0->1 held 10 cycles -> one push only; next cycle
//     valid=1, count=1, rd_data=16'hA5A5; pulse rd_en -> valid=0, rd_data=0.
//   3 Four presses with sw=1,2,3,4, then a 5th with sw=5 -> full=1, count=4,
//     overflow=1; four reads return 1,2,3,4 in order; 5 never appears.
//   4 FIFO full, press (sw=9) coincident with rd_en -> count stays 4, overflow=0;
//     drain returns 2,3,4,9 (after initial 1,2,3,4 fill).
//   5 overflow=1, assert clr_ovf alone -> overflow=0 next cycle; clr_ovf coincident
//     with a dropped push -> overflow stays 1.
//   6 Fill 3 entries, assert rst_n=0 mid-stream for 1 cycle -> count=0, valid=0,
//     full=0, overflow=0 immediately; rd_en while empty -> no change.

Source files
------------

// File: rtl/switch_capture_fifo.sv
// switch_capture_fifo: captures the switch word into a small FIFO on each rising
// edge of the debounced button level. The CPU drains it one word per read strobe.
//   clk, rst_n       clock, asynchronous active-low reset
//   btn_lvl          debounced button level (held, not a pulse)
//   sw               switch word, synchronous to clk
//   rd_en            CPU read strobe (one word per cycle)
//   clr_ovf          clears the sticky overflow flag
//   rd_data          head-of-FIFO word, 0 when empty (fall-through)
//   valid/full/count FIFO occupancy status
//   overflow         sticky: a press was dropped because the FIFO was full
module switch_capture_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_lvl,
  input  logic [DATA_W-1:0] sw,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              btn_q;

  logic push, pop, wr_en, drop;

  // Status derived from the registered count.
  assign valid    = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = valid ? mem_q[rd_ptr_q] : '0;

  // One push per low->high transition; btn_q resets high so a held button
  // through reset release does not push.
  assign push  = btn_lvl & ~btn_q;
  assign pop   = rd_en & valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Next-state for pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
    // A drop in the same cycle as a clear wins.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      btn_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      btn_q    <= btn_lvl;
    end
  end

  // Storage is not reset; rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sw;
  end

endmodule

// File: tb/tb_switch_capture_fifo.sv
module tb_switch_capture_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_lvl;
  logic [15:0] sw;
  logic        rd_en;
  logic        clr_ovf;
  logic [15:0] rd_data;
  logic        valid;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  switch_capture_fifo #(.DATA_W(16), .DEPTH(4), .ADDR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_lvl  (btn_lvl),
    .sw       (sw),
    .rd_en    (rd_en),
    .clr_ovf  (clr_ovf),
    .rd_data  (rd_data),
    .valid    (valid),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising edge on one cycle, released on the next.
  task automatic press(input logic [15:0] d);
    sw = d;
    btn_lvl = 1'b1;
    step();
    btn_lvl = 1'b0;
    step();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] exp);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; btn_lvl = 1'b1; sw = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    step(); step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Button held through reset release: no push.
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("held_count", 32'(count), 32'd0);
    chk("held_valid", 32'(valid), 32'd0);

    // Single long press gives one push.
    btn_lvl = 1'b0;
    step();
    sw = 16'hA5A5; btn_lvl = 1'b1;
    step();
    chk("p1_valid", 32'(valid), 32'd1);
    chk("p1_count", 32'(count), 32'd1);
    chk("p1_data", 32'(rd_data), 32'h0000A5A5);
    for (int i = 0; i < 9; i++) step();
    chk("p1_hold_count", 32'(count), 32'd1);
    btn_lvl = 1'b0;
    rd_chk("p1_rd", 16'hA5A5);
    chk("p1_empty_valid", 32'(valid), 32'd0);
    chk("p1_empty_data", 32'(rd_data), 32'd0);

    // Fill, then overflow on the fifth press.
    for (int i = 1; i <= 4; i++) press(16'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ovf", 32'(overflow), 32'd0);
    press(16'd5);
    chk("of_full", 32'(full), 32'd1);
    chk("of_count", 32'(count), 32'd4);
    chk("of_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) rd_chk($sformatf("of_rd%0d", i), 16'(i));
    chk("of_drained", 32'(valid), 32'd0);
    chk("of_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_alone", 32'(overflow), 32'd0);

    // Push and pop together while full.
    for (int i = 1; i <= 4; i++) press(16'(i));
    sw = 16'd9; btn_lvl = 1'b1; rd_en = 1'b1;
    step();
    btn_lvl = 1'b0; rd_en = 1'b0;
    chk("pp_count", 32'(count), 32'd4);
    chk("pp_ovf", 32'(overflow), 32'd0);
    step();
    rd_chk("pp_rd0", 16'd2);
    rd_chk("pp_rd1", 16'd3);
    rd_chk("pp_rd2", 16'd4);
    rd_chk("pp_rd3", 16'd9);
    chk("pp_drained", 32'(count), 32'd0);

    // Push and pop together while empty: push only.
    sw = 16'h0077; btn_lvl = 1'b1; rd_en = 1'b1;
    step();
    btn_lvl = 1'b0; rd_en = 1'b0;
    chk("pe_count", 32'(count), 32'd1);
    chk("pe_data", 32'(rd_data), 32'h77);
    rd_chk("pe_rd", 16'h0077);

    // Clear coincident with a dropped push: set wins.
    for (int i = 1; i <= 4; i++) press(16'(i));
    press(16'd5);
    chk("cs_pre_ovf", 32'(overflow), 32'd1);
    sw = 16'd6; btn_lvl = 1'b1; clr_ovf = 1'b1;
    step();
    btn_lvl = 1'b0; clr_ovf = 1'b0;
    chk("cs_ovf", 32'(overflow), 32'd1);
    chk("cs_count", 32'(count), 32'd4);
    chk("cs_head", 32'(rd_data), 32'd1);

    // Drain, refill three, then reset mid-stream.
    for (int i = 1; i <= 4; i++) rd_chk($sformatf("cs_rd%0d", i), 16'(i));
    for (int i = 7; i <= 9; i++) press(16'(i));
    chk("r3_count", 32'(count), 32'd3);
    chk("r3_head", 32'(rd_data), 32'd7);
    rst_n = 1'b0;
    #1;
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_valid", 32'(valid), 32'd0);
    chk("mr_full", 32'(full), 32'd0);
    chk("mr_ovf", 32'(overflow), 32'd0);
    chk("mr_data", 32'(rd_data), 32'd0);
    step();
    rst_n = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("er_count", 32'(count), 32'd0);
    chk("er_valid", 32'(valid), 32'd0);
    chk("er_data", 32'(rd_data), 32'd0);

    // Normal operation resumes after reset.
    press(16'h1234);
    chk("post_count", 32'(count), 32'd1);
    chk("post_data", 32'(rd_data), 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
